// File: rtl/fm_demodulator.sv
// ---------------------------------------------------------------------------
// fm_demodulator
//
// This is the receive-side FM demodulator. It takes strobed complex baseband
// samples (I/Q) and recovers the audio sample stream. Each audio sample is the
// phase increment between two consecutive accepted I/Q samples.
//
// An iterative vectoring-mode CORDIC, running one micro-rotation per clock,
// finds the phase of each sample. Phase and data_out use two's complement
// units with full scale +/-pi, so 0x8000 means -pi when WIDTH=16. The delta
// is taken modulo 2^WIDTH, so a step across the +/-pi boundary wraps to the
// short way round on its own.
//
// Timing: the acceptance cycle is cycle 0, and stb_out is high in cycle
// ITERATIONS+2. At most one sample is accepted every ITERATIONS+2 cycles.
// Any stb_in that arrives while a sample is in flight is dropped and is
// flagged on overflow.
//
// Parameters
//   WIDTH       width of signed I, Q, phase and data_out (2..32)
//   ITERATIONS  CORDIC iterations (1..WIDTH, at most 32)
//
// Ports
//   clk       in   1      system clock
//   rst_n     in   1      asynchronous active-low reset
//   i_in      in   WIDTH  signed in-phase sample
//   q_in      in   WIDTH  signed quadrature sample
//   stb_in    in   1      one-cycle strobe, i_in/q_in valid
//   data_out  out  WIDTH  signed demodulated sample (phase delta)
//   stb_out   out  1      one-cycle strobe, data_out valid
//   busy      out  1      high while a sample is in flight
//   overflow  out  1      one-cycle pulse when a stb_in was dropped
// ---------------------------------------------------------------------------
module fm_demodulator #(
   parameter int WIDTH      = 16,
   parameter int ITERATIONS = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] i_in,
   input  logic signed [WIDTH-1:0] q_in,
   input  logic                    stb_in,
   output logic signed [WIDTH-1:0] data_out,
   output logic                    stb_out,
   output logic                    busy,
   output logic                    overflow
);

   // x and y carry two guard bits. They must hold the CORDIC gain (~1.647)
   // applied to a full-scale vector, and also the negation of -2^(WIDTH-1).
   localparam int XW = WIDTH + 2;
   localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROTATE,
      DIFF
   } state_t;

   state_t state;
   state_t state_next;

   logic signed [XW-1:0] x;
   logic signed [XW-1:0] y;
   logic [WIDTH-1:0]     z;
   logic [CW-1:0]        cnt;
   logic                 zero_flag;
   logic [WIDTH-1:0]     prev_phase;
   logic                 primed;
   logic [WIDTH-1:0]     phase_sel;
   logic [WIDTH-1:0]     delta;

   // Each entry is atan(2^-i) in units where pi = 2^31. Entry i is
   // round(atan(2^-i) * 2^31 / pi).
   function automatic logic [31:0] atan_q31(input int idx);
      case (idx)
         0:       return 32'h2000_0000;
         1:       return 32'h12E4_051E;
         2:       return 32'h09FB_385B;
         3:       return 32'h0511_11D4;
         4:       return 32'h028B_0D43;
         5:       return 32'h0145_D7E1;
         6:       return 32'h00A2_F61E;
         7:       return 32'h0051_7C55;
         8:       return 32'h0028_BE53;
         9:       return 32'h0014_5F2F;
         10:      return 32'h000A_2F98;
         11:      return 32'h0005_17CC;
         12:      return 32'h0002_8BE6;
         13:      return 32'h0001_45F3;
         14:      return 32'h0000_A2FA;
         15:      return 32'h0000_517D;
         16:      return 32'h0000_28BE;
         17:      return 32'h0000_145F;
         18:      return 32'h0000_0A30;
         19:      return 32'h0000_0518;
         20:      return 32'h0000_028C;
         21:      return 32'h0000_0146;
         22:      return 32'h0000_00A3;
         23:      return 32'h0000_0051;
         24:      return 32'h0000_0029;
         25:      return 32'h0000_0014;
         26:      return 32'h0000_000A;
         27:      return 32'h0000_0005;
         28:      return 32'h0000_0003;
         29:      return 32'h0000_0001;
         30:      return 32'h0000_0001;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // This rescales a table entry to the working phase scale, where
   // pi = 2^(WIDTH-1). It rounds to nearest, so each entry equals
   // round(atan(2^-i) * 2^(WIDTH-1) / pi).
   function automatic logic [WIDTH-1:0] atan_entry(input int idx);
      logic [32:0] wide;
      wide = {1'b0, atan_q31(idx)};
      if (WIDTH < 32)
         wide = wide + (33'd1 << (31 - WIDTH));
      return WIDTH'(wide >> (32 - WIDTH));
   endfunction

   // In DIFF, an all-zero input vector has no defined angle. For such a
   // sample the phase is held at the previous value, which gives a delta
   // of exactly zero.
   assign phase_sel = zero_flag ? prev_phase : z;
   assign delta     = phase_sel - prev_phase;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic. A strobe is accepted only in IDLE; strobes that
   // arrive in other states never change the state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (stb_in) state_next = ROTATE;
         ROTATE:  if (cnt == LAST_ITER) state_next = DIFF;
         DIFF:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // CORDIC datapath and output registers.
   //
   // On acceptance, the quadrant fixup moves any left-half-plane vector
   // into the right half plane by negating it, and preloads z with pi. The
   // vectoring iterations then only need to cover +/-pi/2.
   //
   // In each micro-rotation, the direction depends on the sign of y, and
   // both updates use the pre-update x and y.
   //
   // In DIFF, the first sample after reset only seeds prev_phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x          <= '0;
         y          <= '0;
         z          <= '0;
         cnt        <= '0;
         zero_flag  <= 1'b0;
         prev_phase <= '0;
         primed     <= 1'b0;
         data_out   <= '0;
         stb_out    <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         stb_out  <= 1'b0;
         overflow <= stb_in && (state != IDLE);
         case (state)
            IDLE: begin
               if (stb_in) begin
                  if (i_in[WIDTH-1]) begin
                     x <= -XW'(i_in);
                     y <= -XW'(q_in);
                     z <= {1'b1, {(WIDTH-1){1'b0}}};
                  end else begin
                     x <= XW'(i_in);
                     y <= XW'(q_in);
                     z <= '0;
                  end
                  zero_flag <= (i_in == '0) && (q_in == '0);
                  cnt       <= '0;
                  busy      <= 1'b1;
               end
            end
            ROTATE: begin
               if (!y[XW-1]) begin
                  x <= x + (y >>> cnt);
                  y <= y - (x >>> cnt);
                  z <= z + atan_entry(int'(cnt));
               end else begin
                  x <= x - (y >>> cnt);
                  y <= y + (x >>> cnt);
                  z <= z - atan_entry(int'(cnt));
               end
               cnt <= cnt + CW'(1);
            end
            DIFF: begin
               if (primed) begin
                  data_out <= delta;
                  stb_out  <= 1'b1;
               end
               prev_phase <= phase_sel;
               primed     <= 1'b1;
               busy       <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fm_demodulator.sv
// ---------------------------------------------------------------------------
// tb_fm_demodulator
//
// This is the self-checking bench for fm_demodulator.
//
// Each accepted I/Q sample pushes its expected phase delta and arrival
// cycle onto a scoreboard. The expected delta comes from an ideal real-valued
// phase model. A negedge monitor collects what the DUT actually emits. Each
// scenario task then drains both queues and compares them inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fm_demodulator;

   localparam int  WIDTH      = 16;
   localparam int  ITERATIONS = 16;
   localparam int  LATENCY    = ITERATIONS + 1;
   localparam int  PERIOD     = ITERATIONS + 2;
   localparam real PI         = 3.14159265358979;
   localparam real SCALE      = 32768.0;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic signed [WIDTH-1:0] i_in;
   logic signed [WIDTH-1:0] q_in;
   logic                    stb_in;
   logic signed [WIDTH-1:0] data_out;
   logic                    stb_out;
   logic                    busy;
   logic                    overflow;

   int  vectors    = 0;
   int  miscompares = 0;
   int  cyc        = 0;
   int  next_free  = 0;
   bit  model_primed = 1'b0;
   real model_prev = 0.0;
   int  ovf_count  = 0;
   int  exp_val_q[$];
   int  exp_cyc_q[$];
   int  obs_val_q[$];
   int  obs_cyc_q[$];

   fm_demodulator #(
      .WIDTH      (WIDTH),
      .ITERATIONS (ITERATIONS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_in     (i_in),
      .q_in     (q_in),
      .stb_in   (stb_in),
      .data_out (data_out),
      .stb_out  (stb_out),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // The monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (stb_out === 1'b1) begin
         obs_val_q.push_back(int'(data_out));
         obs_cyc_q.push_back(cyc);
      end
      if (overflow === 1'b1)
         ovf_count++;
   end

   // This advances one clock. cyc then holds the index of the edge just
   // taken, and inputs change 1 ns after that edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // This gives the absolute difference of two phase values, modulo 2^16.
   function automatic int wrap_err(input int obs, input int expv);
      int d;
      d = (obs - expv) % 65536;
      if (d > 32767)  d -= 65536;
      if (d < -32768) d += 65536;
      return (d < 0) ? -d : d;
   endfunction

   // This drives one strobed phasor for one cycle and updates the model.
   // When amp is zero, the sample is I=Q=0.
   task automatic send(input real amp, input real ph, output bit accepted);
      int  iv;
      int  qv;
      real cur;
      real d;
      iv = int'(amp * $cos(ph * PI));
      qv = int'(amp * $sin(ph * PI));
      i_in   = WIDTH'(iv);
      q_in   = WIDTH'(qv);
      stb_in = 1'b1;
      tick();
      stb_in = 1'b0;
      accepted = (cyc >= next_free);
      if (accepted) begin
         next_free = cyc + PERIOD;
         cur = (iv == 0 && qv == 0) ? model_prev : ph;
         if (model_primed) begin
            d = cur - model_prev;
            while (d >= 1.0)  d -= 2.0;
            while (d < -1.0)  d += 2.0;
            exp_val_q.push_back(int'(d * SCALE));
            exp_cyc_q.push_back(cyc + LATENCY);
         end
         model_prev   = cur;
         model_primed = 1'b1;
      end
   endtask

   task automatic model_reset();
      model_primed = 1'b0;
      model_prev   = 0.0;
      next_free    = cyc;
      exp_val_q.delete();
      exp_cyc_q.delete();
      obs_val_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      stb_in = 1'b0;
      i_in   = '0;
      q_in   = '0;
      repeat (3) tick();
      vectors++;
      if (data_out !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_data_out: got %0d, want 0", data_out);
      end
      vectors++;
      if (stb_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_stb_out: got %b, want 0", stb_out);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_busy: got %b, want 0", busy);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_overflow: got %b, want 0", overflow);
      end
      rst_n = 1'b1;
      tick();
      model_reset();
   endtask

   task automatic test_constant();
      bit acc;
      int ev, ec, ov, oc;
      for (int k = 0; k < 5; k++) begin
         send(16000.0, 0.0, acc);
         if (k == 0) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL const_busy: got %b, want 1", busy);
            end
         end
         repeat (PERIOD - 1) tick();
      end
      repeat (4) tick();
      vectors++;
      if (exp_val_q.size() != 4) begin
         miscompares++;
         $display("[TB] FAIL const_count: model queued %0d, want 4", exp_val_q.size());
      end
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL const_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > 2) begin
               miscompares++;
               $display("[TB] FAIL const_value: got %0d, want %0d +/-2", ov, ev);
            end
            vectors++;
            if (oc !== ec) begin
               miscompares++;
               $display("[TB] FAIL const_latency: got cycle %0d, want %0d", oc, ec);
            end
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL const_extra: got %0d extra stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
      vectors++;
      if (wrap_err(int'(data_out), 0) > 2) begin
         miscompares++;
         $display("[TB] FAIL const_hold: got %0d, want 0 +/-2", data_out);
      end
   endtask

   task automatic test_step();
      bit  acc;
      int  ev, ec, ov, oc;
      real ph;
      ph = 0.0;
      for (int k = 0; k < 6; k++) begin
         send(16000.0, ph, acc);
         repeat (PERIOD - 1) tick();
         ph = ph + 0.125;
      end
      for (int k = 0; k < 5; k++) begin
         ph = ph - 0.5;
         if (ph < -1.0) ph = ph + 2.0;
         send(16000.0, ph, acc);
         repeat (PERIOD - 1) tick();
      end
      repeat (4) tick();
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL step_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > 4) begin
               miscompares++;
               $display("[TB] FAIL step_value: got %0d, want %0d +/-4", ov, ev);
            end
            vectors++;
            if (oc !== ec) begin
               miscompares++;
               $display("[TB] FAIL step_latency: got cycle %0d, want %0d", oc, ec);
            end
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL step_extra: got %0d extra stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
   endtask

   task automatic test_wrap();
      bit acc;
      int ev, ec, ov, oc;
      send(16000.0, 0.9, acc);
      repeat (PERIOD - 1) tick();
      send(16000.0, -0.9, acc);
      repeat (PERIOD - 1) tick();
      send(16000.0, -0.7, acc);
      repeat (PERIOD + 4) tick();
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > 4 || ((ev > 0) && (ov < 0))) begin
               miscompares++;
               $display("[TB] FAIL wrap_value: got %0d, want %0d +/-4", ov, ev);
            end
            vectors++;
            if (oc !== ec) begin
               miscompares++;
               $display("[TB] FAIL wrap_latency: got cycle %0d, want %0d", oc, ec);
            end
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL wrap_extra: got %0d extra stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
   endtask

   task automatic test_overflow();
      bit acc;
      int ev, ec, ov, oc;
      int drops;
      int ovf_start;
      int prev_oc;
      drops     = 0;
      ovf_start = ovf_count;
      prev_oc   = -1000;
      for (int k = 0; k < 12; k++) begin
         send(16000.0, 0.1 * k, acc);
         if (!acc) drops++;
         repeat (4) tick();
      end
      repeat (PERIOD + 4) tick();
      vectors++;
      if ((ovf_count - ovf_start) != drops) begin
         miscompares++;
         $display("[TB] FAIL ovf_pulses: got %0d, want %0d", ovf_count - ovf_start, drops);
      end
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > 4) begin
               miscompares++;
               $display("[TB] FAIL ovf_value: got %0d, want %0d +/-4", ov, ev);
            end
            vectors++;
            if (oc !== ec || (oc - prev_oc) < PERIOD) begin
               miscompares++;
               $display("[TB] FAIL ovf_timing: got cycle %0d (prev %0d), want %0d", oc, prev_oc, ec);
            end
            prev_oc = oc;
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL ovf_extra: got %0d extra stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
   endtask

   task automatic test_zero();
      bit acc;
      int ev, ec, ov, oc;
      send(16000.0, 0.25, acc);
      repeat (PERIOD - 1) tick();
      send(0.0, 0.0, acc);
      repeat (PERIOD - 1) tick();
      send(16000.0, 0.5, acc);
      repeat (PERIOD + 4) tick();
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL zero_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > ((ev == 0) ? 0 : 4)) begin
               miscompares++;
               $display("[TB] FAIL zero_value: got %0d, want %0d", ov, ev);
            end
            vectors++;
            if (oc !== ec) begin
               miscompares++;
               $display("[TB] FAIL zero_latency: got cycle %0d, want %0d", oc, ec);
            end
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL zero_extra: got %0d extra stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
   endtask

   task automatic test_reset_midflight();
      bit acc;
      int ev, ec, ov, oc;
      send(16000.0, 0.3, acc);
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if (data_out !== '0 || stb_out !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: got data_out=%0d stb_out=%b busy=%b overflow=%b, want all 0",
                  data_out, stb_out, busy, overflow);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      model_reset();
      repeat (PERIOD + 2) tick();
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_aborted: got %0d stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
      send(16000.0, 0.1, acc);
      repeat (PERIOD - 1) tick();
      vectors++;
      if (obs_val_q.size() != 0 || exp_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_prime: got %0d stb_out, want 0", obs_val_q.size());
         obs_val_q.delete();
         obs_cyc_q.delete();
      end
      send(16000.0, 0.3, acc);
      repeat (PERIOD + 4) tick();
      while (exp_val_q.size() > 0) begin
         ev = exp_val_q.pop_front();
         ec = exp_cyc_q.pop_front();
         vectors++;
         if (obs_val_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_missing: got no stb_out, want data_out=%0d", ev);
         end else begin
            ov = obs_val_q.pop_front();
            oc = obs_cyc_q.pop_front();
            if (wrap_err(ov, ev) > 4) begin
               miscompares++;
               $display("[TB] FAIL midreset_value: got %0d, want %0d +/-4", ov, ev);
            end
            vectors++;
            if (oc !== ec) begin
               miscompares++;
               $display("[TB] FAIL midreset_latency: got cycle %0d, want %0d", oc, ec);
            end
         end
      end
      vectors++;
      if (obs_val_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_extra: got %0d extra stb_out, want 0", obs_val_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_step();
      test_wrap();
      test_overflow();
      test_zero();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
